// File: rtl/pkt_framer_pkg.sv
// Shared types for the multi-channel packet framer.
// Channel state encoding, length width and per-beat action bundle.
package pkt_framer_pkg;

    localparam int LEN_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_DATA = 3'd2,
        ST_TAIL = 3'd3,
        ST_DROP = 3'd4
    } ch_state_e;

    // What the addressed channel wants done with the current beat.
    typedef struct packed {
        logic fwd;
        logic sop;
        logic eop;
        logic err;
        logic ev;
    } ch_act_t;

endpackage

// File: rtl/pkt_framer_ch.sv
// One framing channel: packet FSM plus beat length counter.
// The beat action is combinational; state advances only when sel is high.
module pkt_framer_ch
    import pkt_framer_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      sel,
    input  logic      head,
    input  logic      tail,
    output ch_state_e state,
    output ch_act_t   act
);

    ch_state_e        state_q;
    ch_state_e        state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [LEN_W-1:0] len_inc;

    assign len_inc = len_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        act     = '0;
        case (state_q)
            ST_HEAD, ST_DATA: begin
                act.fwd = 1'b1;
                len_d   = len_inc;
                if (tail) begin
                    act.eop = 1'b1;
                    state_d = ST_TAIL;
                end else if (head) begin
                    act.eop = 1'b1;
                    act.err = 1'b1;
                    act.ev  = 1'b1;
                    state_d = ST_IDLE;
                end else if (len_inc == LEN_W'(MAX_LEN)) begin
                    act.eop = 1'b1;
                    act.err = 1'b1;
                    act.ev  = 1'b1;
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                // IDLE, TAIL and DROP all restart cleanly on a head
                if (head) begin
                    act.fwd = 1'b1;
                    act.sop = 1'b1;
                    act.eop = tail;
                    len_d   = LEN_W'(1);
                    state_d = tail ? ST_TAIL : ST_HEAD;
                end else if (state_q == ST_DROP) begin
                    if (tail) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    act.ev  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (!sel) begin
            state_d = state_q;
            len_d   = len_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pkt_framer.sv
// Multi-channel packet framer with a single registered output stage.
// Define PKT_FRAMER_ERR_COUNT_EN to build the saturating error counter.
module pkt_framer
    import pkt_framer_pkg::*;
#(
    parameter int  NUM_CH  = 4,
    parameter int  DATA_W  = 8,
    parameter int  MAX_LEN = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_head,
    input  logic                in_tail,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic                out_sop,
    output logic                out_eop,
    output logic                out_err,
    output logic [CH_W-1:0]     out_ch,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic [3*NUM_CH-1:0] state_vec,
    output logic [15:0]         err_count
);

    ch_state_e         ch_state [NUM_CH];
    ch_act_t           ch_act   [NUM_CH];
    logic [NUM_CH-1:0] ch_sel;
    ch_act_t           act;
    logic              ch_ok;
    logic              accept;
    logic              load;
    logic              err_ev;

    logic              out_valid_q, out_valid_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic              out_err_q, out_err_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    assign in_ready = reset | ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~reset;
    assign ch_ok    = int'(in_ch) < NUM_CH;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_sel[i] = accept & (in_ch == CH_W'(i));

        pkt_framer_ch #(
            .MAX_LEN(MAX_LEN)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .sel  (ch_sel[i]),
            .head (in_head),
            .tail (in_tail),
            .state(ch_state[i]),
            .act  (ch_act[i])
        );

        assign state_vec[3*i +: 3] = ch_state[i];
    end

    // Out-of-range channels are swallowed and flagged as orphans.
    always_comb begin
        act = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                act = ch_act[i];
            end
        end
        if (!ch_ok) begin
            act    = '0;
            act.ev = 1'b1;
        end
    end

    assign load   = accept & act.fwd;
    assign err_ev = accept & act.ev;

    always_comb begin
        out_valid_d = out_valid_q & ~out_ready;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_err_d   = out_err_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_sop_d   = act.sop;
            out_eop_d   = act.eop;
            out_err_d   = act.err;
            out_ch_d    = in_ch;
            out_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_err_q   <= out_err_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_err   = out_err_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

`ifdef PKT_FRAMER_ERR_COUNT_EN
    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_ev && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_err_ev;
    assign unused_err_ev = err_ev;
    assign err_count     = '0;
`endif

endmodule
